// File: rtl/pwm_hbridge_dt_pkg.sv
// rtl/pwm_hbridge_dt_pkg.sv - shared constants, sample clamp and parameter legality check
package pwm_pkg;

  localparam int MODE_BD = 0;
  localparam int MODE_AD = 1;

  // Wide arithmetic so clamping the most negative IN_W sample cannot overflow.
  function automatic longint clamp(input longint v, input longint lim);
    longint r;
    r = v;
    if (v > lim) r = lim;
    if (v < -lim) r = -lim;
    return r;
  endfunction

  function automatic bit params_ok(input int half, input int cnt_w, input int in_w,
                                   input int deadtime, input int mode);
    return (half > 0) && (cnt_w > 0) && (cnt_w < 31) && ((1 << cnt_w) > 2 * half) &&
           (in_w >= 2) && (in_w < 64) && (deadtime >= 0) && (deadtime < half) &&
           ((mode == MODE_BD) || (mode == MODE_AD));
  endfunction

endpackage

// File: rtl/pwm_hbridge_dt_if.sv
// rtl/pwm_hbridge_dt_if.sv - sample/enable inputs and gate outputs of the H-bridge modulator
interface pwm_hbridge_dt_if #(
  parameter int IN_W = 32
);
  logic                   en;
  logic signed [IN_W-1:0] sample;
  logic                   period_start;
  logic                   sat;
  logic                   ha_hi;
  logic                   ha_lo;
  logic                   hb_hi;
  logic                   hb_lo;

  modport master (
    output en, sample,
    input  period_start, sat, ha_hi, ha_lo, hb_hi, hb_lo
  );

  modport slave (
    input  en, sample,
    output period_start, sat, ha_hi, ha_lo, hb_hi, hb_lo
  );
endinterface

// File: rtl/pwm_hbridge_dt_deadtime.sv
// rtl/pwm_hbridge_dt_deadtime.sv - per-leg dead-time: a gate turns on only after the ideal level has held DEADTIME cycles
module pwm_deadtime #(
  parameter int DEADTIME = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ideal,
  output logic hi,
  output logic lo
);
  localparam int RW = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [RW-1:0] DT_MAX = RW'(DEADTIME);

  logic [RW-1:0] prev_run;
  logic [RW-1:0] run;
  logic          ideal_d;
  logic          en_q;
  logic          dt_done;

  // run = cycles the current ideal level has already held, saturating at DEADTIME.
  always_comb begin
    run = '0;
    if (en_q && (ideal == ideal_d)) begin
      if (prev_run >= DT_MAX) run = DT_MAX;
      else                    run = prev_run + 1'b1;
    end
  end

  assign dt_done = (run >= DT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      ideal_d  <= 1'b0;
      prev_run <= '0;
    end else if (!en) begin
      en_q     <= 1'b0;
      ideal_d  <= 1'b0;
      prev_run <= '0;
    end else begin
      en_q     <= 1'b1;
      ideal_d  <= ideal;
      prev_run <= run;
    end
  end

  // Opposite polarities of ideal make hi and lo mutually exclusive by construction.
  assign hi = en_q &  ideal & dt_done;
  assign lo = en_q & ~ideal & dt_done;
endmodule

// File: rtl/pwm_hbridge_dt.sv
// rtl/pwm_hbridge_dt.sv - center-aligned two-leg H-bridge PWM with BD/AD modulation and dead-time
module pwm_hbridge_dt
  import pwm_pkg::*;
#(
  parameter int HALF     = 20,
  parameter int CNT_W    = 8,
  parameter int IN_W     = 32,
  parameter int DEADTIME = 2,
  parameter int MODE     = 0
) (
  input  logic            clk,
  input  logic            rst,
  pwm_hbridge_dt_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(2 * HALF - 1);
  localparam logic [CNT_W:0]   HALF_W = (CNT_W + 1)'(HALF);

  if (!params_ok(HALF, CNT_W, IN_W, DEADTIME, MODE)) begin : g_bad_params
    $error("pwm_hbridge_dt: illegal HALF/CNT_W/IN_W/DEADTIME/MODE combination");
  end

  logic signed [IN_W-1:0] smp;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       k_a;
  logic [CNT_W-1:0]       k_b;
  logic [CNT_W-1:0]       k_a_nxt;
  logic [CNT_W-1:0]       k_b_nxt;
  logic [CNT_W:0]         win_lo_a, win_hi_a, win_lo_b, win_hi_b;
  logic                   cmp_a, cmp_b;
  logic                   ideal_a, ideal_b;
  logic                   do_latch;
  logic                   sat_q;
  logic                   ps_q;
  longint                 s_ext;
  longint                 x;

  assign smp      = bus.sample;
  assign do_latch = bus.en && (count == LAST);

  always_comb begin
    s_ext   = longint'(smp);
    x       = clamp(s_ext, longint'(HALF));
    k_a_nxt = '0;
    k_b_nxt = '0;
    if (MODE == MODE_AD) begin
      // HALF + x is never negative, so the shift is an exact floor.
      k_a_nxt = CNT_W'((longint'(HALF) + x) >>> 1);
      k_b_nxt = CNT_W'(HALF) - k_a_nxt;
    end else if (x > 0) begin
      k_a_nxt = CNT_W'(x);
    end else begin
      k_b_nxt = CNT_W'(-x);
    end
  end

  // Window [HALF-k, HALF+k) is centred on count==HALF; k==HALF covers the whole period.
  always_comb begin
    win_lo_a = HALF_W - {1'b0, k_a};
    win_hi_a = HALF_W + {1'b0, k_a};
    win_lo_b = HALF_W - {1'b0, k_b};
    win_hi_b = HALF_W + {1'b0, k_b};
    cmp_a    = ({1'b0, count} >= win_lo_a) && ({1'b0, count} < win_hi_a);
    cmp_b    = ({1'b0, count} >= win_lo_b) && ({1'b0, count} < win_hi_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= LAST;
      k_a     <= '0;
      k_b     <= '0;
      sat_q   <= 1'b0;
      ps_q    <= 1'b0;
      ideal_a <= 1'b0;
      ideal_b <= 1'b0;
    end else begin
      ps_q    <= (count == '0);
      ideal_a <= bus.en && cmp_a;
      ideal_b <= bus.en && cmp_b;
      if (!bus.en)            count <= LAST;
      else if (count == LAST) count <= '0;
      else                    count <= count + 1'b1;
      // Both legs reload on the same edge so the bridge never mixes two samples.
      if (do_latch) begin
        k_a   <= k_a_nxt;
        k_b   <= k_b_nxt;
        sat_q <= (x != s_ext);
      end
    end
  end

  assign bus.period_start = ps_q;
  assign bus.sat          = sat_q;

  pwm_deadtime #(.DEADTIME(DEADTIME)) u_dt_a (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .ideal (ideal_a),
    .hi    (bus.ha_hi),
    .lo    (bus.ha_lo)
  );

  pwm_deadtime #(.DEADTIME(DEADTIME)) u_dt_b (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .ideal (ideal_b),
    .hi    (bus.hb_hi),
    .lo    (bus.hb_lo)
  );
endmodule

// File: doc/pwm_hbridge_dt.md
Name: pwm_hbridge_dt

Overview:
- Parametrised successor to the single-leg center-aligned PWM generator in the class-D amplifier output stage.
- Drives a full H-bridge: two legs, each with complementary high-side and low-side gates.
- Programmable period, selectable modulation mode (three-level BD or two-level AD), dead-time insertion, atomic once-per-period sample update, saturation flag and enable gating.
- Sits between the loop filter/quantiser output (signed sample) and the gate-driver pins.

Parameters:
- HALF, 20: half PWM period in clk cycles; period P = 2*HALF (200 MHz / 40 = 5 MHz default).
- CNT_W, 8: counter width; must satisfy 2^CNT_W > 2*HALF.
- IN_W, 32: width of the signed two's-complement sample.
- DEADTIME, 2: dead-time in clk cycles; 0 <= DEADTIME < HALF.
- MODE, 0: 0 = three-level BD, 1 = two-level AD.

Ports:
- clk  in  1  system clock (200 MHz)
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low forces all gates off
- sample  in  IN_W  signed modulation value, sampled once per period
- period_start  out  1  one-cycle pulse when count==0 (upstream sample request)
- sat  out  1  last latched sample was clamped
- ha_hi  out  1  leg A high-side gate
- ha_lo  out  1  leg A low-side gate
- hb_hi  out  1  leg B high-side gate
- hb_lo  out  1  leg B low-side gate

Behaviour:
- Reset (async, rst=1):
  - count = P-1; kA = kB = 0; sat = 0; period_start = 0.
  - All four gates = 0; dead-time counters = 0.
- Counter:
  - While en=1, count runs 0..P-1 and wraps to 0.
  - While en=0, count is held at P-1.
- Latch:
  - Occurs on the cycle where en=1 and count==P-1.
  - x = clamp(sample, -HALF, +HALF), computed at IN_W+1 bits with no overflow.
  - sat <= (x != sample).
  - kA and kB update together (atomic), taking effect from count 0.
  - MODE 0 (BD): kA = max(x,0); kB = max(-x,0).
  - MODE 1 (AD): kA = floor((HALF+x)/2); kB = HALF - kA.
- Ideal leg waveform:
  - idealL registered = (HALF-kL <= count < HALF+kL); width 2*kL, centred on count==HALF.
  - k=0 gives constant low; k=HALF gives constant high, with no glitch across the wrap.
- Dead-time, per leg:
  - L_hi rises only after idealL has been 1 for DEADTIME consecutive cycles (counted from the ideal edge).
  - L_lo rises only after idealL has been 0 for DEADTIME consecutive cycles.
  - Both gates fall on the first cycle after the ideal edge.
  - L_hi and L_lo are never 1 in the same cycle (invariant).
  - High pulses of width <= DEADTIME suppress L_hi entirely; L_lo is still off for that width plus DEADTIME.
  - DEADTIME=0: L_hi = idealL and L_lo = ~idealL, one cycle after the compare.
- Latency:
  - Gate assertion occurs 1+DEADTIME cycles after the count compare; deassertion after 1 cycle.
- period_start: registered pulse, high for the single cycle following count==0.
- Enable:
  - en 1->0: the next cycle forces all gates to 0, count to P-1 and dead-time counters to 0.
  - en 0->1: latch on the first enabled cycle, count 0 on the next.
  - Low-sides are also 0 while disabled (bridge floating).
  - Re-enable applies full dead-time before any gate asserts.
- sample is don't-care except on latch cycles.
- Mid-period changes to sample have no effect.

Decomposition:
- Shared package pwm_pkg holds:
  - mode constants MODE_BD=0 and MODE_AD=1;
  - the clamp function;
  - HALF/DEADTIME legality checks (elaboration-time assertion).
- Sub-module pwm_deadtime (one instance per leg):
  - inputs clk, rst, en, ideal; outputs hi, lo; parameter DEADTIME.
  - Contains the per-leg dead-time counter.

Test Plan (HALF=20, DEADTIME=2 unless noted):
- BD, sample=+10 held:
  - ideal A high for count 10..29.
  - ha_hi high 20 cycles minus 2 (asserts 3 cycles after count==10).
  - hb_hi always 0 and hb_lo always 1; sat=0.
- BD, sample=-100:
  - kB=20 and sat=1.
  - hb_hi constantly 1 across the wrap with no glitch; ha_hi=0.
  - Then sample=+25: kA=20, sat=1.
- AD (MODE=1), sample=0:
  - kA=kB=10; both legs high for count 10..29, in phase.
  - sample=+20: kA=20 (A always high), kB=0 (B always low).
- Atomic update: change sample at count==5, 19 and 39 within one period.
  - Only the value present at count==39 appears in the next period.
  - Both legs switch together.
- Dead-time, sample=+1 (ideal width 2 = DEADTIME):
  - ha_hi never asserts; ha_lo low for 4 cycles around the centre.
  - hi&&lo==0 asserted on every cycle for a random sample sweep.
- Reset/enable:
  - Assert rst mid-pulse: all outputs 0 immediately (async).
  - Release with en=1: period_start pulses one cycle after the first count 0.
  - Toggling en low mid-pulse: gates 0 on the next cycle.
